// File: rtl/display_timing_gen.sv
// Raster timing generator: beam counters, sync/enable decode and a runtime
// mode switch that only takes effect on a frame boundary.
`timescale 1ns/1ps
module display_timing_gen #(
    parameter int COORD_W         = 13,
    parameter int OUT_DELAY       = 0,
    parameter int H_RESOLUTION    = 640,
    parameter int H_FRONT_PORCH   = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK_PORCH    = 48,
    parameter int V_RESOLUTION    = 480,
    parameter int V_FRONT_PORCH   = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK_PORCH    = 33,
    parameter bit H_SYNC_POLARITY = 1'b0,
    parameter bit V_SYNC_POLARITY = 1'b0
) (
    input  logic                      i_pixel_clk,
    input  logic                      i_reset,
    input  logic                      i_cfg_valid,
    output logic                      o_cfg_ready,
    input  logic [4*COORD_W-1:0]      i_cfg_h,
    input  logic [4*COORD_W-1:0]      i_cfg_v,
    input  logic [1:0]                i_cfg_pol,
    output logic                      o_cfg_err,
    output logic [2:0]                o_hvesync,
    output logic                      o_frame_start,
    output logic                      o_line_start,
    output logic signed [COORD_W-1:0] o_x,
    output logic signed [COORD_W-1:0] o_y,
    output logic [15:0]               o_frame_count
);
    localparam int unsigned W  = COORD_W;
    localparam int unsigned MW = 4 * W;
    localparam int unsigned TW = W + 2;
    localparam int unsigned VW = 5 + 2 * W + 16;

    localparam logic signed [W-1:0] ONE = W'(1);
    localparam logic [MW-1:0] RST_H =
        {W'(H_RESOLUTION), W'(H_FRONT_PORCH), W'(H_SYNC), W'(H_BACK_PORCH)};
    localparam logic [MW-1:0] RST_V =
        {W'(V_RESOLUTION), W'(V_FRONT_PORCH), W'(V_SYNC), W'(V_BACK_PORCH)};
    localparam logic [1:0] RST_POL = {V_SYNC_POLARITY, H_SYNC_POLARITY};

    // Field 3 = resolution, 2 = front porch, 1 = sync, 0 = back porch.
    function automatic logic [W-1:0] fld(input logic [MW-1:0] m, input int unsigned i);
        return m[i*W +: W];
    endfunction

    function automatic logic signed [W-1:0] start_of(input logic [MW-1:0] m);
        return -$signed(fld(m, 2) + fld(m, 1) + fld(m, 0));
    endfunction

    function automatic logic mode_ok(input logic [MW-1:0] m);
        logic [TW-1:0] total;
        total = TW'(fld(m, 3)) + TW'(fld(m, 2)) + TW'(fld(m, 1)) + TW'(fld(m, 0));
        return (fld(m, 3) != '0) && (fld(m, 1) != '0) && (total[TW-1:W-1] == '0);
    endfunction

    // Output bundle for a beam position; the sync pulse sits at the polarity level.
    function automatic logic [VW-1:0] encode(
        input logic signed [W-1:0] x,
        input logic signed [W-1:0] y,
        input logic [15:0]         fc,
        input logic [MW-1:0]       mh,
        input logic [MW-1:0]       mv,
        input logic [1:0]          pol
    );
        logic signed [W-1:0] hs0, hs1, vs0, vs1;
        logic de, hs, vs, fs, ls;
        hs0 = start_of(mh) + $signed(fld(mh, 2));
        hs1 = hs0 + $signed(fld(mh, 1));
        vs0 = start_of(mv) + $signed(fld(mv, 2));
        vs1 = vs0 + $signed(fld(mv, 1));
        de  = !x[W-1] && !y[W-1];
        hs  = ((x > hs0) && (x <= hs1)) ? pol[0] : !pol[0];
        vs  = ((y > vs0) && (y <= vs1)) ? pol[1] : !pol[1];
        ls  = (x == start_of(mh));
        fs  = ls && (y == start_of(mv));
        return {de, vs, hs, fs, ls, x, y, fc};
    endfunction

    localparam logic [VW-1:0] RST_VEC =
        encode(start_of(RST_H), start_of(RST_V), 16'd0, RST_H, RST_V, RST_POL);

    logic [MW-1:0]       mode_h, mode_v, shadow_h, shadow_v;
    logic [1:0]          mode_pol, shadow_pol;
    logic                pending, cfg_err;
    logic signed [W-1:0] x, y, h_last, v_last;
    logic [15:0]         frame_count;
    logic [VW-1:0]       cur_vec, out_vec;

    assign h_last  = $signed(fld(mode_h, 3) - W'(1));
    assign v_last  = $signed(fld(mode_v, 3) - W'(1));
    assign cur_vec = encode(x, y, frame_count, mode_h, mode_v, mode_pol);

    // Beam counters, config shadow and frame-boundary mode switch.
    always_ff @(posedge i_pixel_clk) begin
        if (i_reset) begin
            mode_h      <= RST_H;
            mode_v      <= RST_V;
            mode_pol    <= RST_POL;
            shadow_h    <= '0;
            shadow_v    <= '0;
            shadow_pol  <= '0;
            pending     <= 1'b0;
            cfg_err     <= 1'b0;
            x           <= start_of(RST_H);
            y           <= start_of(RST_V);
            frame_count <= 16'd0;
        end else begin
            cfg_err <= 1'b0;
            if (i_cfg_valid && !pending) begin
                if (mode_ok(i_cfg_h) && mode_ok(i_cfg_v)) begin
                    shadow_h   <= i_cfg_h;
                    shadow_v   <= i_cfg_v;
                    shadow_pol <= i_cfg_pol;
                    pending    <= 1'b1;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
            if (x == h_last) begin
                x <= start_of(mode_h);
                if (y == v_last) begin
                    y           <= start_of(mode_v);
                    frame_count <= frame_count + 16'd1;
                    if (pending) begin
                        mode_h   <= shadow_h;
                        mode_v   <= shadow_v;
                        mode_pol <= shadow_pol;
                        x        <= start_of(shadow_h);
                        y        <= start_of(shadow_v);
                        pending  <= 1'b0;
                    end
                end else begin
                    y <= y + ONE;
                end
            end else begin
                x <= x + ONE;
            end
        end
    end

    generate
        if (OUT_DELAY == 0) begin : g_nodly
            assign out_vec = cur_vec;
        end else begin : g_dly
            logic [OUT_DELAY-1:0][VW-1:0] dly;
            // Reset flushes every stage to the start-of-frame encoding.
            always_ff @(posedge i_pixel_clk) begin
                if (i_reset) begin
                    for (int i = 0; i < OUT_DELAY; i++) dly[i] <= RST_VEC;
                end else begin
                    for (int i = OUT_DELAY - 1; i > 0; i--) dly[i] <= dly[i-1];
                    dly[0] <= cur_vec;
                end
            end
            assign out_vec = dly[OUT_DELAY-1];
        end
    endgenerate

    assign {o_hvesync, o_frame_start, o_line_start, o_x, o_y, o_frame_count} = out_vec;
    assign o_cfg_ready = !pending;
    assign o_cfg_err   = cfg_err;
endmodule

// File: tb/tb_display_timing_gen.sv
// Directed bench: default-mode line timing, a small-mode instance exercising
// mode switches/reset, and a 3-stage delayed twin compared against it.
`timescale 1ns/1ps
module tb_display_timing_gen;
    localparam int W  = 13;
    localparam int VW = 5 + 2 * W + 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_valid = 1'b0;
    logic idle_valid = 1'b0;
    logic [4*W-1:0] cfg_h = '0, cfg_v = '0, idle_cfg = '0;
    logic [1:0] cfg_pol = 2'b00, idle_pol = 2'b00;

    logic d_ready, d_err, d_fs, d_ls;
    logic [2:0] d_hvs;
    logic signed [W-1:0] d_x, d_y;
    logic [15:0] d_fc;
    logic a_ready, a_err, a_fs, a_ls;
    logic [2:0] a_hvs;
    logic signed [W-1:0] a_x, a_y;
    logic [15:0] a_fc;
    logic b_ready, b_err, b_fs, b_ls;
    logic [2:0] b_hvs;
    logic signed [W-1:0] b_x, b_y;
    logic [15:0] b_fc;

    int n_checks = 0;
    int n_fail = 0;
    int n_dly = 0;
    int dly_mism = 0;
    logic [VW-1:0] hist[$];

    wire [VW-1:0] a_vec = {a_hvs, a_fs, a_ls, a_x, a_y, a_fc};
    wire [VW-1:0] b_vec = {b_hvs, b_fs, b_ls, b_x, b_y, b_fc};

    always #5 clk = ~clk;

    display_timing_gen dut_def (
        .i_pixel_clk(clk), .i_reset(rst), .i_cfg_valid(idle_valid), .o_cfg_ready(d_ready),
        .i_cfg_h(idle_cfg), .i_cfg_v(idle_cfg), .i_cfg_pol(idle_pol), .o_cfg_err(d_err),
        .o_hvesync(d_hvs), .o_frame_start(d_fs), .o_line_start(d_ls),
        .o_x(d_x), .o_y(d_y), .o_frame_count(d_fc)
    );

    display_timing_gen #(
        .COORD_W(W), .OUT_DELAY(0),
        .H_RESOLUTION(10), .H_FRONT_PORCH(2), .H_SYNC(3), .H_BACK_PORCH(1),
        .V_RESOLUTION(6), .V_FRONT_PORCH(1), .V_SYNC(2), .V_BACK_PORCH(1)
    ) dut_a (
        .i_pixel_clk(clk), .i_reset(rst), .i_cfg_valid(a_valid), .o_cfg_ready(a_ready),
        .i_cfg_h(cfg_h), .i_cfg_v(cfg_v), .i_cfg_pol(cfg_pol), .o_cfg_err(a_err),
        .o_hvesync(a_hvs), .o_frame_start(a_fs), .o_line_start(a_ls),
        .o_x(a_x), .o_y(a_y), .o_frame_count(a_fc)
    );

    display_timing_gen #(
        .COORD_W(W), .OUT_DELAY(3),
        .H_RESOLUTION(10), .H_FRONT_PORCH(2), .H_SYNC(3), .H_BACK_PORCH(1),
        .V_RESOLUTION(6), .V_FRONT_PORCH(1), .V_SYNC(2), .V_BACK_PORCH(1)
    ) dut_b (
        .i_pixel_clk(clk), .i_reset(rst), .i_cfg_valid(a_valid), .o_cfg_ready(b_ready),
        .i_cfg_h(cfg_h), .i_cfg_v(cfg_v), .i_cfg_pol(cfg_pol), .o_cfg_err(b_err),
        .o_hvesync(b_hvs), .o_frame_start(b_fs), .o_line_start(b_ls),
        .o_x(b_x), .o_y(b_y), .o_frame_count(b_fc)
    );

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [4*W-1:0] pk(input int r, input int f, input int s, input int b);
        return {W'(r), W'(f), W'(s), W'(b)};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Delayed twin must trail the undelayed instance by exactly three clocks.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            hist.delete();
            hist.push_back(a_vec);
        end else begin
            hist.push_back(a_vec);
            if (hist.size() > 3) begin
                logic [VW-1:0] exp_v;
                exp_v = hist.pop_front();
                n_dly++;
                if (b_vec !== exp_v) dly_mism++;
            end
        end
        if (b_ready !== a_ready || b_err !== a_err) dly_mism++;
    end

    // Walks dut_a until the next frame_start, collecting timing statistics.
    task automatic run_frame(input logic hpol, input logic vpol,
                             output int clocks, output int de_n, output int hs_n,
                             output int vs_n, output int ls_n, output int hs_x0,
                             output int hs_x1);
        clocks = 0; de_n = 0; hs_n = 0; vs_n = 0; ls_n = 0; hs_x0 = 9999; hs_x1 = 9999;
        do begin
            if (a_hvs[2]) de_n++;
            if (a_hvs[0] == hpol) begin
                if (hs_n == 0) hs_x0 = a_x;
                hs_x1 = a_x;
                hs_n++;
            end
            if (a_hvs[1] == vpol) vs_n++;
            if (a_ls) ls_n++;
            step();
            clocks++;
        end while (!a_fs && clocks < 5000);
    endtask

    initial begin
        int clocks, de_n, hs_n, vs_n, ls_n, x0, x1, lo, fc0;
        logic found;

        repeat (3) step();
        rst = 1'b0;
        check_eq("def_rst_x", d_x, -160);
        check_eq("def_rst_y", d_y, -45);
        check_eq("def_rst_fs", d_fs, 1);
        check_eq("def_rst_ls", d_ls, 1);
        check_eq("def_rst_hvs", d_hvs, 3);
        check_eq("def_rst_fc", d_fc, 0);
        check_eq("def_rst_ready", d_ready, 1);
        check_eq("def_rst_err", d_err, 0);
        check_eq("a_rst_x", a_x, -6);
        check_eq("a_rst_y", a_y, -4);
        check_eq("a_rst_fs", a_fs, 1);

        // One default-mode line: 800 clocks, hsync low over x=-143..-48.
        lo = 0; x0 = 9999; x1 = 9999; de_n = 0;
        for (int i = 0; i < 800; i++) begin
            if (!d_hvs[0]) begin
                if (lo == 0) x0 = d_x;
                x1 = d_x;
                lo++;
            end
            if (d_hvs[2]) de_n++;
            step();
        end
        check_eq("def_hs_len", lo, 96);
        check_eq("def_hs_first_x", x0, -143);
        check_eq("def_hs_last_x", x1, -48);
        check_eq("def_de_blank_line", de_n, 0);
        check_eq("def_line2_x", d_x, -160);
        check_eq("def_line2_y", d_y, -44);
        check_eq("def_line2_ls", d_ls, 1);
        check_eq("def_line2_fs", d_fs, 0);

        // Parameter mode of dut_a: 16x10 total, 10x6 active.
        check_eq("a_at_fs", a_fs, 1);
        fc0 = a_fc;
        run_frame(1'b0, 1'b0, clocks, de_n, hs_n, vs_n, ls_n, x0, x1);
        check_eq("a0_frame_clk", clocks, 160);
        check_eq("a0_de", de_n, 60);
        check_eq("a0_hs", hs_n, 30);
        check_eq("a0_vs", vs_n, 32);
        check_eq("a0_lines", ls_n, 10);
        check_eq("a0_hs_x0", x0, -3);
        check_eq("a0_hs_x1", x1, -1);
        check_eq("a0_fc_inc", a_fc, (fc0 + 1) % 65536);

        // Mid-frame config: old frame completes, then 14x7 mode with positive syncs.
        repeat (20) step();
        check_eq("a1_ready_idle", a_ready, 1);
        cfg_h = pk(8, 2, 2, 2); cfg_v = pk(4, 1, 1, 1); cfg_pol = 2'b11; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        check_eq("a1_ready_busy", a_ready, 0);
        run_frame(1'b0, 1'b0, clocks, de_n, hs_n, vs_n, ls_n, x0, x1);
        check_eq("a1_old_rest", clocks, 139);
        check_eq("a1_new_x", a_x, -6);
        check_eq("a1_new_y", a_y, -3);
        check_eq("a1_ready_back", a_ready, 1);
        run_frame(1'b1, 1'b1, clocks, de_n, hs_n, vs_n, ls_n, x0, x1);
        check_eq("a1_frame_clk", clocks, 98);
        check_eq("a1_de", de_n, 32);
        check_eq("a1_hs", hs_n, 14);
        check_eq("a1_vs", vs_n, 14);
        check_eq("a1_lines", ls_n, 7);
        check_eq("a1_hs_x0", x0, -3);
        check_eq("a1_hs_x1", x1, -2);

        // Zero sync width is rejected.
        cfg_h = pk(8, 2, 0, 2); cfg_v = pk(4, 1, 1, 1); cfg_pol = 2'b00; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        check_eq("a2_err_pulse", a_err, 1);
        check_eq("a2_ready", a_ready, 1);
        step();
        check_eq("a2_err_clear", a_err, 0);
        run_frame(1'b1, 1'b1, clocks, de_n, hs_n, vs_n, ls_n, x0, x1);
        check_eq("a2_unchanged", clocks, 96);

        // Config on the last-pixel clock waits one further old-mode frame.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (a_x == 7 && a_y == 3) found = 1'b1;
            else step();
        end
        check_eq("a3_found_last", found, 1);
        cfg_h = pk(12, 1, 1, 1); cfg_v = pk(5, 1, 1, 1); cfg_pol = 2'b00; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        check_eq("a3_ready_busy", a_ready, 0);
        check_eq("a3_old_x", a_x, -6);
        check_eq("a3_old_y", a_y, -3);
        run_frame(1'b1, 1'b1, clocks, de_n, hs_n, vs_n, ls_n, x0, x1);
        check_eq("a3_old_frame", clocks, 98);
        check_eq("a3_new_x", a_x, -3);
        check_eq("a3_new_y", a_y, -3);
        check_eq("a3_ready_back", a_ready, 1);
        run_frame(1'b0, 1'b0, clocks, de_n, hs_n, vs_n, ls_n, x0, x1);
        check_eq("a3_frame_clk", clocks, 120);
        check_eq("a3_de", de_n, 60);
        check_eq("a3_hs", hs_n, 8);
        check_eq("a3_vs", vs_n, 15);
        check_eq("a3_lines", ls_n, 8);

        // Mid-frame reset with a pending config discards it.
        repeat (10) step();
        cfg_h = pk(8, 2, 2, 2); cfg_v = pk(4, 1, 1, 1); cfg_pol = 2'b11; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        check_eq("a4_pending", a_ready, 0);
        repeat (5) step();
        rst = 1'b1;
        step();
        check_eq("a4_rst_x", a_x, -6);
        check_eq("a4_rst_y", a_y, -4);
        check_eq("a4_rst_fc", a_fc, 0);
        check_eq("a4_rst_ready", a_ready, 1);
        check_eq("a4_rst_fs", a_fs, 1);
        check_eq("a4_def_rst_x", d_x, -160);
        rst = 1'b0;
        run_frame(1'b0, 1'b0, clocks, de_n, hs_n, vs_n, ls_n, x0, x1);
        check_eq("a4_frame1", clocks, 160);
        run_frame(1'b0, 1'b0, clocks, de_n, hs_n, vs_n, ls_n, x0, x1);
        check_eq("a4_frame2", clocks, 160);
        check_eq("a4_fc", a_fc, 2);

        step();
        check_eq("dly_mismatches", dly_mism, 0);
        check_eq("dly_samples_seen", n_dly > 500, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
